// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage stall/flush responder: owns the PC and the IF/ID latch, honours the
// hazard unit's write enables and the EX-stage redirect, and keeps stall/flush statistics.
module fetch_stall_ctrl #(
  parameter int                 PC_W       = 32,
  parameter int                 INSTR_W    = 64,
  parameter int                 PC_STEP    = 8,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] NOP_BUNDLE = '0,
  parameter int                 STALL_MAX  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCWrite,
  input  logic               IF_IDWrite,
  input  logic               ControlMux,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               id_ctrl_en,
  output logic               id_ex_flush,
  output logic [15:0]        stall_count,
  output logic [15:0]        flush_count,
  output logic               stall_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       stall;
  logic [7:0] run_cnt;
  logic [7:0] run_cnt_next;
  logic       timeout_hit;

  assign stall = !PCWrite || !IF_IDWrite;

  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    if (branch_taken) begin
      state_next   = FLUSH;
      run_cnt_next = 8'd0;
    end else if (stall) begin
      state_next   = STALL;
      run_cnt_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    end else begin
      state_next   = RUN;
      run_cnt_next = 8'd0;
    end
  end

  // Trip on the same edge that makes the run counter reach the limit.
  assign timeout_hit = (run_cnt_next >= 8'(STALL_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      run_cnt <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_next;
      run_cnt <= run_cnt_next;
      stall_timeout <= stall_timeout | timeout_hit;
    end
  end

  // The hazard unit's enables are ignored during a redirect; the redirect must win.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_BUNDLE;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      if_id_instr <= NOP_BUNDLE;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      flush_count <= (flush_count == 16'hFFFF) ? flush_count : flush_count + 16'd1;
    end else begin
      if (PCWrite) begin
        pc <= pc + PC_W'(PC_STEP);
      end
      if (IF_IDWrite) begin
        if_id_instr <= imem_rdata;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
      end
      if (stall) begin
        stall_count <= (stall_count == 16'hFFFF) ? stall_count : stall_count + 16'd1;
      end
    end
  end

  assign id_ex_flush = (state == FLUSH);
  assign id_ctrl_en  = ControlMux & if_id_valid;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed table-driven bench for fetch_stall_ctrl; instruction memory returns
// a PC-tagged bundle {pc, ~pc} so every latched bundle identifies its address.
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset, PCWrite, IF_IDWrite, ControlMux, branch_taken;
  logic [31:0] branch_target;
  logic [63:0] imem_rdata;
  logic [31:0] pc, if_id_pc;
  logic [63:0] if_id_instr;
  logic        if_id_valid, id_ctrl_en, id_ex_flush, stall_timeout;
  logic [15:0] stall_count, flush_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {pc, ~pc};

  fetch_stall_ctrl dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .ControlMux(ControlMux), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .id_ctrl_en(id_ctrl_en), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .flush_count(flush_count), .stall_timeout(stall_timeout)
  );

  typedef struct {
    logic        rst, pcw, ifw, cm, bt;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_ifpc;
    logic        e_v, e_fl, e_ce;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(logic rst, logic pcw, logic ifw, logic cm, logic bt,
                              logic [31:0] tgt, logic [31:0] e_pc, logic [31:0] e_ifpc,
                              logic e_v, logic e_fl, logic e_ce,
                              logic [15:0] e_sc, logic [15:0] e_fc);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.cm = cm; v.bt = bt; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_v = e_v; v.e_fl = e_fl; v.e_ce = e_ce;
    v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic pcw, input logic ifw, input logic cm,
                       input logic bt, input logic [31:0] tgt);
    reset = rst; PCWrite = pcw; IF_IDWrite = ifw; ControlMux = cm;
    branch_taken = bt; branch_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    //          rst  pcw  ifw  cm   bt   tgt           pc            ifpc          v    fl   ce   sc      fc
    vt[0]  = mk(1'b1,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b0,16'd0,16'd0);
    vt[1]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h8,        32'h0,        1'b1,1'b0,1'b1,16'd0,16'd0);
    vt[2]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h10,       32'h8,        1'b1,1'b0,1'b1,16'd0,16'd0);
    vt[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h8,        1'b1,1'b0,1'b0,16'd1,16'd0);
    vt[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h8,        1'b1,1'b0,1'b0,16'd2,16'd0);
    vt[5]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h18,       32'h10,       1'b1,1'b0,1'b1,16'd2,16'd0);
    vt[6]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h20,       32'h18,       1'b1,1'b0,1'b1,16'd2,16'd0);
    vt[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h100,      32'h100,      32'h0,        1'b0,1'b1,1'b0,16'd2,16'd1);
    vt[8]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h108,      32'h100,      1'b1,1'b0,1'b1,16'd2,16'd1);
    vt[9]  = mk(1'b0,1'b1,1'b1,1'b1,1'b1,32'h40,       32'h40,       32'h0,        1'b0,1'b1,1'b0,16'd2,16'd2);
    vt[10] = mk(1'b0,1'b1,1'b1,1'b1,1'b1,32'h80,       32'h80,       32'h0,        1'b0,1'b1,1'b0,16'd2,16'd3);
    vt[11] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h88,       32'h80,       1'b1,1'b0,1'b1,16'd2,16'd3);
    vt[12] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        32'h88,       32'h88,       1'b1,1'b0,1'b1,16'd3,16'd3);
    vt[13] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,        32'h90,       32'h88,       1'b1,1'b0,1'b1,16'd4,16'd3);
    vt[14] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'h98,       32'h90,       1'b1,1'b0,1'b1,16'd4,16'd3);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].pcw, vt[i].ifw, vt[i].cm, vt[i].bt, vt[i].tgt);
      tick();
      chk($sformatf("v%0d pc", i), 64'(pc), 64'(vt[i].e_pc));
      chk($sformatf("v%0d valid", i), 64'(if_id_valid), 64'(vt[i].e_v));
      chk($sformatf("v%0d flush", i), 64'(id_ex_flush), 64'(vt[i].e_fl));
      chk($sformatf("v%0d ctrl_en", i), 64'(id_ctrl_en), 64'(vt[i].e_ce));
      chk($sformatf("v%0d stall_cnt", i), 64'(stall_count), 64'(vt[i].e_sc));
      chk($sformatf("v%0d flush_cnt", i), 64'(flush_count), 64'(vt[i].e_fc));
      chk($sformatf("v%0d timeout", i), 64'(stall_timeout), 64'd0);
      if (vt[i].e_v || vt[i].rst) begin
        chk($sformatf("v%0d if_pc", i), 64'(if_id_pc), 64'(vt[i].e_ifpc));
      end
      if (vt[i].e_v) begin
        chk($sformatf("v%0d instr", i), if_id_instr, {vt[i].e_ifpc, ~vt[i].e_ifpc});
      end else begin
        chk($sformatf("v%0d nop", i), if_id_instr, 64'h0);
      end
    end

    // Watchdog: an interrupted run must not trip it; 15 consecutive stalls must.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("wd 14 stalls", 64'(stall_timeout), 64'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("wd after break", 64'(stall_timeout), 64'd0);
    tick();
    chk("wd trip", 64'(stall_timeout), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("wd sticky", 64'(stall_timeout), 64'd1);
    chk("wd pc", 64'(pc), 64'h20);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    chk("wd reset", 64'(stall_timeout), 64'd0);

    // PC wrap-around through a redirect to the top of the address space.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8); tick();
    chk("wrap tgt", 64'(pc), 64'hFFFF_FFF8);
    chk("wrap flush", 64'(id_ex_flush), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    chk("wrap pc", 64'(pc), 64'h0);
    chk("wrap if_pc", 64'(if_id_pc), 64'hFFFF_FFF8);
    chk("wrap flush end", 64'(id_ex_flush), 64'd0);

    // Stall counter saturation, then reset overriding a redirect mid-stall.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 70000; i++) tick();
    chk("sat stall_cnt", 64'(stall_count), 64'hFFFF);
    chk("sat timeout", 64'(stall_timeout), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200); tick();
    chk("rst pc", 64'(pc), 64'h0);
    chk("rst valid", 64'(if_id_valid), 64'd0);
    chk("rst flush", 64'(id_ex_flush), 64'd0);
    chk("rst stall_cnt", 64'(stall_count), 64'd0);
    chk("rst flush_cnt", 64'(flush_count), 64'd0);
    chk("rst timeout", 64'(stall_timeout), 64'd0);
    chk("rst instr", if_id_instr, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stall_ctrl.md
# fetch_stall_ctrl

Front-end responder to the hazard detection unit. Owns the PC register and the IF/ID pipeline latch, and applies the decode-stage control gating. Honours the hazard unit's `PCWrite`, `IF_IDWrite` and `ControlMux` outputs and the EX-stage branch redirect. Sits between instruction memory and the decode stage of the VLIW pipeline. Also keeps saturating stall/flush statistics and a stuck-stall watchdog.

## Interface
- `PC_W`, 32, PC width in bits
- `INSTR_W`, 64, VLIW bundle width (two 32-bit ops)
- `PC_STEP`, 8, PC increment per bundle (bytes)
- `RESET_PC`, 0, PC value after reset
- `NOP_BUNDLE`, 0, bundle loaded into IF/ID on flush/reset
- `STALL_MAX`, 15, consecutive stall cycles before watchdog trips (1..255)
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `PCWrite`  in  1  from hazard unit; 0 = hold PC
- `IF_IDWrite`  in  1  from hazard unit; 0 = hold IF/ID latch
- `ControlMux`  in  1  from hazard unit; 0 = insert bubble into ID/EX
- `branch_taken`  in  1  EX-stage taken-branch redirect strobe
- `branch_target`  in  PC_W  redirect address, valid with `branch_taken`
- `imem_rdata`  in  INSTR_W  combinational instruction memory read data for `pc`
- `pc`  out  PC_W  current fetch address (also instruction memory address)
- `if_id_instr`  out  INSTR_W  latched bundle
- `if_id_pc`  out  PC_W  PC of latched bundle
- `if_id_valid`  out  1  latched bundle is a real instruction
- `id_ctrl_en`  out  1  combinational: `ControlMux & if_id_valid`; 0 zeroes ID/EX controls
- `id_ex_flush`  out  1  registered one-cycle pulse to flush the wrong-path op in ID/EX
- `stall_count`  out  16  saturating count of stall cycles
- `flush_count`  out  16  saturating count of redirects
- `stall_timeout`  out  1  sticky watchdog error flag

## Operation
- FSM states: RUN, STALL, FLUSH. Reset state RUN.
- Per-cycle priority: `reset` > `branch_taken` > stall > normal advance.
- Reset: `pc`=RESET_PC, `if_id_instr`=NOP_BUNDLE, `if_id_pc`=0, `if_id_valid`=0, `id_ex_flush`=0, both counters 0, `stall_timeout`=0, internal stall-run counter 0. `reset` overrides every other input in the same cycle.
- Redirect (`branch_taken`=1, any state):
  - `pc`<=`branch_target`.
  - IF/ID <= NOP_BUNDLE, `if_id_valid`<=0.
  - Next state FLUSH. `id_ex_flush`<=1.
  - `flush_count`++ (saturate at 0xFFFF).
  - `PCWrite`/`IF_IDWrite` are ignored. The hazard unit drops them whenever Branch is high, and the redirect must still win.
- Stall (no redirect, `PCWrite`=0 or `IF_IDWrite`=0):
  - Each enable is applied independently. If `PCWrite`=0, `pc` holds, else `pc`+=PC_STEP. If `IF_IDWrite`=0, IF/ID holds, else it loads.
  - Next state STALL.
  - `stall_count`++ (saturate). Stall-run counter ++ (saturate at 255).
- Normal (no redirect, both enables 1):
  - `pc`<=`pc`+PC_STEP, wrapping modulo 2^PC_W.
  - `if_id_instr`<=`imem_rdata`, `if_id_pc`<=`pc`, `if_id_valid`<=1.
  - Next state RUN. Stall-run counter <=0.
- FLUSH lasts exactly one cycle:
  - `id_ex_flush` is 1 only while in FLUSH.
  - Fetch at the target proceeds per the stall/normal rules in that same cycle.
  - Leaves to RUN or STALL per the inputs, or re-enters FLUSH on a back-to-back redirect.
- Watchdog: when the stall-run counter reaches STALL_MAX, `stall_timeout`<=1. It stays 1 until `reset`. It does not alter pipeline behaviour.
- `id_ctrl_en` is purely combinational. A bubble is produced for `ControlMux`=0 and for an invalid IF/ID entry.

## Timing
- All outputs except `id_ctrl_en` are registered and change only on the rising edge.
- Fetch latency: the bundle at `pc` in cycle N appears on `if_id_instr` in cycle N+1, provided `IF_IDWrite`=1.
- Redirect latency:
  - `branch_taken` in cycle N gives `pc`=target, `if_id_valid`=0 and `id_ex_flush`=1 in cycle N+1.
  - The target bundle is valid in IF/ID in cycle N+2 if no stall occurs.
- A stall of k cycles delays fetch by exactly k cycles. No bundle is lost or duplicated.
- Counters update in the same edge as the event they count. They hold at 0xFFFF.

## Test plan
- Reset then free-run 4 cycles, RESET_PC=0, imem returns PC-tagged data: `pc`=0,8,16,24,32. IF/ID holds bundles for 0,8,16,24 with `if_id_valid`=1 from cycle 1.
- Load-use stall: assert PCWrite=IF_IDWrite=ControlMux=0 for 2 cycles at `pc`=0x10. Required: `pc` holds 0x10, IF/ID holds the 0x08 bundle, `id_ctrl_en`=0, `stall_count`=2, then normal resume at 0x18.
- Redirect while hazard stall is asserted (branch_taken=1, target=0x100, PCWrite=0): next cycle `pc`=0x100, `if_id_valid`=0, `id_ex_flush`=1, `flush_count`=1. The following cycle `id_ex_flush`=0 and the 0x100 bundle is latched.
- Back-to-back redirects to 0x40 then 0x80: `id_ex_flush` stays high 2 cycles, `flush_count`=2, final `pc` resumes from 0x80.
- Stuck stall for STALL_MAX=15 cycles: `stall_timeout` rises after the 15th stall edge and remains 1 after stalls clear. It clears only on `reset`.
- Wrap and saturation:
  - `pc`=0xFFFF_FFF8 advances to 0.
  - Force 70000 stall cycles: `stall_count` holds 0xFFFF.
  - Assert `reset` mid-stall together with `branch_taken`: all reset values apply, and `pc`=RESET_PC.
